// File: rtl/perf_counter_dump_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : perf_pkg
//  Description : Shared definitions for the performance-counter readout path:
//                dump transmitter state encoding, frame geometry, default
//                frame header and the counter-order indices used by the
//                counter block, the dump transmitter and host-side decode.
//  Revision    : 1.0 - initial release
// ============================================================================
package perf_pkg;

    // Dump transmitter states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        CHK  = 2'd3
    } dump_state_e;

    // Frame geometry: HEADER + data bytes + CHK
    localparam int FRAME_DATA_BYTES = 12;
    localparam int FRAME_BYTES      = FRAME_DATA_BYTES + 2;

    // Default first byte of every frame
    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    // Counter order: position of each counter in the frame and in any
    // array of counters shared between blocks. Each counter occupies two
    // data bytes, high byte first.
    localparam int NUM_COUNTERS = 6;
    localparam int CNT_INSTR    = 0;
    localparam int CNT_LOADS    = 1;
    localparam int CNT_STORES   = 2;
    localparam int CNT_ALU      = 3;
    localparam int CNT_CONTROLS = 4;
    localparam int CNT_CYCLES   = 5;

endpackage
`default_nettype wire

// File: rtl/perf_counter_dump_tx.sv
`default_nettype none
// ============================================================================
//  Module      : perf_counter_dump_tx
//  Description : Snapshots the six 16-bit performance counters on request
//                and serializes them as a 14-byte frame
//                (HEADER, 12 data bytes high-first, XOR checksum) over a
//                byte-wide valid/ready stream.
//  Ports       : clk, reset (sync, active-high)
//                total_instructions .. clock_cycles : live counter inputs
//                dump_req    : start-of-frame request (pulse or level)
//                tx_data/tx_valid/tx_ready : byte stream to the sink
//                busy        : frame in progress
//                done        : one-cycle pulse after the CHK byte is taken
//                req_dropped : one-cycle pulse for a request seen while busy
//  Revision    : 1.0 - initial release
// ============================================================================
module perf_counter_dump_tx
    import perf_pkg::*;
#(
    parameter logic [7:0] HEADER = HEADER_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] total_instructions,
    input  logic [15:0] total_loads,
    input  logic [15:0] total_stores,
    input  logic [15:0] total_alu,
    input  logic [15:0] total_controls,
    input  logic [15:0] clock_cycles,
    input  logic        dump_req,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic        req_dropped
);

    localparam logic [3:0] c_LAST_DATA_IDX = 4'(FRAME_DATA_BYTES - 1);

    dump_state_e r_state;
    logic [15:0] r_snap [NUM_COUNTERS];
    logic [3:0]  r_idx;
    logic [7:0]  r_chk;

    logic        w_fire;
    logic [3:0]  w_sel;
    logic [7:0]  w_sel_byte;
    logic [7:0]  w_chk_next;

    assign w_fire     = tx_valid && tx_ready;
    assign w_chk_next = r_chk ^ tx_data;
    assign busy       = (r_state != IDLE);

    // tx_data is registered, so the mux looks one byte ahead: while the
    // header is on the wire it selects data byte 0, and while data byte
    // r_idx is on the wire it selects byte r_idx+1.
    assign w_sel = (r_state == DATA) ? (r_idx + 4'd1) : 4'd0;

    always_comb begin
        w_sel_byte = 8'h00;
        case (w_sel)
            4'd0:    w_sel_byte = r_snap[CNT_INSTR][15:8];
            4'd1:    w_sel_byte = r_snap[CNT_INSTR][7:0];
            4'd2:    w_sel_byte = r_snap[CNT_LOADS][15:8];
            4'd3:    w_sel_byte = r_snap[CNT_LOADS][7:0];
            4'd4:    w_sel_byte = r_snap[CNT_STORES][15:8];
            4'd5:    w_sel_byte = r_snap[CNT_STORES][7:0];
            4'd6:    w_sel_byte = r_snap[CNT_ALU][15:8];
            4'd7:    w_sel_byte = r_snap[CNT_ALU][7:0];
            4'd8:    w_sel_byte = r_snap[CNT_CONTROLS][15:8];
            4'd9:    w_sel_byte = r_snap[CNT_CONTROLS][7:0];
            4'd10:   w_sel_byte = r_snap[CNT_CYCLES][15:8];
            4'd11:   w_sel_byte = r_snap[CNT_CYCLES][7:0];
            default: w_sel_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= 4'd0;
            r_chk       <= 8'h00;
            tx_data     <= 8'h00;
            tx_valid    <= 1'b0;
            done        <= 1'b0;
            req_dropped <= 1'b0;
            for (int k = 0; k < NUM_COUNTERS; k++) begin
                r_snap[k] <= 16'h0000;
            end
        end else begin
            done        <= 1'b0;
            // Requests during a frame are discarded, only reported.
            req_dropped <= dump_req && (r_state != IDLE);

            case (r_state)
                IDLE: begin
                    if (dump_req) begin
                        r_snap[CNT_INSTR]    <= total_instructions;
                        r_snap[CNT_LOADS]    <= total_loads;
                        r_snap[CNT_STORES]   <= total_stores;
                        r_snap[CNT_ALU]      <= total_alu;
                        r_snap[CNT_CONTROLS] <= total_controls;
                        r_snap[CNT_CYCLES]   <= clock_cycles;
                        r_idx    <= 4'd0;
                        r_chk    <= 8'h00;
                        tx_data  <= HEADER;
                        tx_valid <= 1'b1;
                        r_state  <= HDR;
                    end
                end
                HDR: begin
                    if (w_fire) begin
                        tx_data <= w_sel_byte;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_fire) begin
                        r_chk <= w_chk_next;
                        if (r_idx == c_LAST_DATA_IDX) begin
                            // Checksum includes the byte being accepted now.
                            tx_data <= w_chk_next;
                            r_state <= CHK;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            tx_data <= w_sel_byte;
                        end
                    end
                end
                CHK: begin
                    if (w_fire) begin
                        tx_valid <= 1'b0;
                        tx_data  <= 8'h00;
                        done     <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_perf_counter_dump_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_perf_counter_dump_tx
//  Description : Self-checking bench for perf_counter_dump_tx. A monitor
//                drives tx_ready and collects accepted bytes; frames are
//                compared against a frame model built from the counter
//                values present at the request edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_perf_counter_dump_tx;

    typedef logic [5:0][15:0] cnt_t;   // [0]=instructions ... [5]=cycles

    typedef struct {
        cnt_t       cnt;
        bit         rnd;
        logic [7:0] exp_chk;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] total_instructions, total_loads, total_stores;
    logic [15:0] total_alu, total_controls, clock_cycles;
    logic        dump_req;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy, done, req_dropped;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          rand_ready = 1'b0;
    logic [7:0]  rx [$];
    int          busy_cycles = 0;
    int          done_cnt = 0;
    int          drop_cnt = 0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    vec_t        vecs [6];

    always #5 clk = ~clk;

    perf_counter_dump_tx #(.HEADER(8'hA5)) dut (
        .clk                (clk),
        .reset              (reset),
        .total_instructions (total_instructions),
        .total_loads        (total_loads),
        .total_stores       (total_stores),
        .total_alu          (total_alu),
        .total_controls     (total_controls),
        .clock_cycles       (clock_cycles),
        .dump_req           (dump_req),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .busy               (busy),
        .done               (done),
        .req_dropped        (req_dropped)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic cnt_t mk(input logic [15:0] a, b, c, d, e, f);
        cnt_t r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e; r[5] = f;
        return r;
    endfunction

    function automatic cnt_t rand_cnt();
        cnt_t r;
        for (int k = 0; k < 6; k++) r[k] = 16'($urandom);
        return r;
    endfunction

    // Frame model: position 0 header, 1..12 counter bytes high-first,
    // 13 the XOR of all counter bytes.
    function automatic logic [7:0] model_byte(input cnt_t c, input int pos);
        logic [7:0] x;
        if (pos == 0) return 8'hA5;
        if (pos == 13) begin
            x = 8'h00;
            for (int k = 0; k < 6; k++) x = x ^ c[k][15:8] ^ c[k][7:0];
            return x;
        end
        if (pos % 2 == 1) return c[(pos - 1) / 2][15:8];
        return c[(pos - 1) / 2][7:0];
    endfunction

    task automatic set_cnt(input cnt_t c);
        total_instructions = c[0];
        total_loads        = c[1];
        total_stores       = c[2];
        total_alu          = c[3];
        total_controls     = c[4];
        clock_cycles       = c[5];
    endtask

    // Sink side: sample outputs just after each edge, check the hold rule,
    // pick tx_ready for the next edge and record bytes that will handshake.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (prev_valid && !prev_ready) begin
                check("hold_valid", 32'(tx_valid), 32'd1);
                check("hold_data", 32'(tx_data), 32'(prev_data));
            end
            if (busy)        busy_cycles++;
            if (done)        done_cnt++;
            if (req_dropped) drop_cnt++;
        end
        tx_ready = rand_ready ? (($urandom & 1) != 0) : 1'b1;
        if (tx_valid && tx_ready) rx.push_back(tx_data);
        prev_valid = tx_valid;
        prev_ready = tx_ready;
        prev_data  = tx_data;
    end

    // Request a frame; with now=1 the request is driven in the current cycle.
    task automatic start_frame(input cnt_t c, input bit rnd, input bit now, input string tag);
        rand_ready = rnd;
        if (!now) @(negedge clk);
        rx.delete();
        set_cnt(c);
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        check({tag, "_lat_valid"}, 32'(tx_valid), 32'd1);
        check({tag, "_lat_hdr"}, 32'(tx_data), 32'hA5);
        check({tag, "_lat_busy"}, 32'(busy), 32'd1);
    endtask

    // Wait for done (bounded), then compare the collected frame.
    task automatic finish_frame(input cnt_t c, input bit churn, input string tag);
        for (int i = 0; i < 400; i++) begin
            if (done) break;
            if (churn) set_cnt(rand_cnt());
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_len"}, 32'(rx.size()), 32'd14);
        for (int p = 0; p < 14; p++) begin
            check($sformatf("%s_byte%0d", tag, p),
                  (p < rx.size()) ? 32'(rx[p]) : 32'h1FF, 32'(model_byte(c, p)));
        end
    endtask

    task automatic wait_rx(input int n, input string tag);
        for (int i = 0; i < 300 && rx.size() < n; i++) @(negedge clk);
        check({tag, "_reached"}, 32'(rx.size() >= n), 32'd1);
    endtask

    initial begin
        int   b0, d0, r0;
        cnt_t c;

        vecs[0] = '{mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000), 1'b0, 8'h00};
        vecs[1] = '{mk(16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 16'h0B0C), 1'b0, 8'h0C};
        vecs[2] = '{mk(16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 16'h0B0C), 1'b1, 8'h0C};
        vecs[3] = '{mk(16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001), 1'b1, 8'h81};
        vecs[4] = '{mk(16'h00FF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000), 1'b0, 8'hFF};
        vecs[5] = '{mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 1'b1, 8'h00};

        reset    = 1'b1;
        dump_req = 1'b0;
        set_cnt('0);
        repeat (3) @(negedge clk);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_req_dropped", 32'(req_dropped), 32'd0);
        reset = 1'b0;

        // Table-driven frames
        for (int v = 0; v < 6; v++) begin
            b0 = busy_cycles;
            start_frame(vecs[v].cnt, vecs[v].rnd, 1'b0, $sformatf("vec%0d", v));
            finish_frame(vecs[v].cnt, 1'b0, $sformatf("vec%0d", v));
            check($sformatf("vec%0d_chk_table", v),
                  (rx.size() == 14) ? 32'(rx[13]) : 32'h1FF, 32'(vecs[v].exp_chk));
            if (!vecs[v].rnd)
                check($sformatf("vec%0d_busy_cycles", v), 32'(busy_cycles - b0), 32'd14);
        end

        // Counter inputs change every cycle during the frame
        c = rand_cnt();
        start_frame(c, 1'b1, 1'b0, "churn");
        finish_frame(c, 1'b1, "churn");

        // Request arriving at byte 5 is dropped and does not queue a frame
        c  = rand_cnt();
        r0 = drop_cnt;
        d0 = done_cnt;
        start_frame(c, 1'b0, 1'b0, "drop");
        wait_rx(5, "drop");
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        finish_frame(c, 1'b0, "drop");
        repeat (20) @(negedge clk);
        check("drop_pulses", 32'(drop_cnt - r0), 32'd1);
        check("drop_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("drop_no_second_frame", 32'(rx.size()), 32'd14);
        check("drop_idle_valid", 32'(tx_valid), 32'd0);

        // Request in the done cycle starts the next frame immediately
        c  = rand_cnt();
        r0 = drop_cnt;
        start_frame(c, 1'b1, 1'b0, "b2b_a");
        finish_frame(c, 1'b0, "b2b_a");
        c = rand_cnt();
        start_frame(c, 1'b1, 1'b1, "b2b_b");
        finish_frame(c, 1'b0, "b2b_b");
        check("b2b_no_drop", 32'(drop_cnt - r0), 32'd0);

        // Reset at byte 7 aborts the frame
        c = rand_cnt();
        start_frame(c, 1'b0, 1'b0, "rstmid");
        wait_rx(7, "rstmid");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstmid_valid", 32'(tx_valid), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        d0 = done_cnt;
        repeat (20) @(negedge clk);
        check("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
        check("rstmid_no_resume", 32'(tx_valid), 32'd0);
        c = rand_cnt();
        start_frame(c, 1'b0, 1'b0, "after_rst");
        finish_frame(c, 1'b0, "after_rst");

        // Reset and request together: reset wins
        @(negedge clk);
        reset    = 1'b1;
        dump_req = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        dump_req = 1'b0;
        check("rst_req_valid", 32'(tx_valid), 32'd0);
        check("rst_req_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("rst_req_valid_later", 32'(tx_valid), 32'd0);

        // Randomized frames against the model
        for (int n = 0; n < 8; n++) begin
            c = rand_cnt();
            start_frame(c, 1'b1, 1'b0, $sformatf("rnd%0d", n));
            finish_frame(c, (($urandom & 1) != 0), $sformatf("rnd%0d", n));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
